// File: rtl/commit_queue_if.sv
// commit_queue_if -- bundle of all non-clock/reset signals of commit_queue.
//
// Handshake: an enqueue group (in_valid/in_wen/in_addr/in_data) is taken at
// a rising edge only when in_ready=1 and flush=0. The producer must hold the
// group stable until that edge; in_ready depends only on registered
// occupancy, never on in_valid.
//
// Signals:
//   flush, stall              : control from the pipeline (master -> slave)
//   in_valid/in_wen[LANES]    : per-lane result present / needs regfile write
//   in_addr[LANES][5]         : destination register per lane
//   in_data[LANES][32]        : result value per lane
//   in_ready                  : a full LANES-wide group fits this cycle
//   regfile_write_ena/addr/data : regfile write ports, one per lane
//   commit_valid/commit_result  : retiring entries, oldest in lane 0
//   count                     : number of occupied entries
// Modports: master drives the inputs of the queue, slave is the queue.
interface commit_queue_if #(
   parameter int LANES = 2,
   parameter int DEPTH = 8
);
   logic                            flush;
   logic                            stall;
   logic [LANES-1:0]                in_valid;
   logic [LANES-1:0]                in_wen;
   logic [LANES-1:0][4:0]           in_addr;
   logic [LANES-1:0][31:0]          in_data;
   logic                            in_ready;
   logic [LANES-1:0]                regfile_write_ena;
   logic [LANES-1:0][4:0]           regfile_write_addr;
   logic [LANES-1:0][31:0]          regfile_write_data;
   logic [LANES-1:0]                commit_valid;
   logic [LANES-1:0][31:0]          commit_result;
   logic [$clog2(DEPTH):0]          count;

   modport master (
      output flush, stall, in_valid, in_wen, in_addr, in_data,
      input  in_ready, regfile_write_ena, regfile_write_addr,
             regfile_write_data, commit_valid, commit_result, count
   );

   modport slave (
      input  flush, stall, in_valid, in_wen, in_addr, in_data,
      output in_ready, regfile_write_ena, regfile_write_addr,
             regfile_write_data, commit_valid, commit_result, count
   );
endinterface

// File: rtl/commit_queue.sv
// commit_queue -- in-order commit buffer feeding LANES regfile write ports.
//
// Results arrive as groups of up to LANES contiguous lanes (lane 0 oldest)
// and are stored in a circular buffer. Each cycle, unless stalled or
// flushed, up to LANES of the oldest entries retire combinationally from
// the head and drive the regfile write ports. Within a retiring group only
// the youngest writer of a given register is enabled (WAW collapse).
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (pointers/count only)
//   bus   : commit_queue_if.slave, see the interface for signal meanings
module commit_queue #(
   parameter int LANES = 2,
   parameter int DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   commit_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [CW-1:0] count_q;

   // Entry storage is deliberately not reset; occupancy alone decides
   // which entries are observable.
   logic          mem_wen  [DEPTH];
   logic [4:0]    mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];

   logic          enq_fire;
   logic [CW-1:0] enq_n;
   logic [CW-1:0] ret_k;

   logic [LANES-1:0]        cv;
   logic [LANES-1:0]        h_wen;
   logic [LANES-1:0][4:0]   h_addr;
   logic [LANES-1:0][31:0]  h_data;
   logic [LANES-1:0]        ena;

   assign bus.in_ready = (CW'(DEPTH) - count_q) >= CW'(LANES);
   assign bus.count    = count_q;

   // Lanes are contiguous from lane 0, so the population count is also the
   // tail advance.
   always_comb begin
      enq_n = '0;
      for (int i = 0; i < LANES; i++) begin
         enq_n = enq_n + CW'(bus.in_valid[i]);
      end
      enq_fire = bus.in_ready && !bus.flush && (bus.in_valid != '0);
   end

   always_comb begin
      ret_k = '0;
      if (!bus.flush && !bus.stall) begin
         ret_k = (count_q < CW'(LANES)) ? count_q : CW'(LANES);
      end
   end

   // Head window: lane j looks at head+j, wrapping naturally in PW bits.
   always_comb begin
      logic [PW-1:0] idx;
      idx    = '0;
      cv     = '0;
      h_wen  = '0;
      h_addr = '0;
      h_data = '0;
      for (int j = 0; j < LANES; j++) begin
         idx       = head_q + PW'(j);
         cv[j]     = CW'(j) < ret_k;
         h_wen[j]  = mem_wen[idx];
         h_addr[j] = mem_addr[idx];
         h_data[j] = mem_data[idx];
      end
   end

   // An older write is dropped only when a younger retiring entry actually
   // writes the same register; a younger non-writing entry does not hide it.
   always_comb begin
      ena = '0;
      for (int j = 0; j < LANES; j++) begin
         ena[j] = cv[j] && h_wen[j] && (h_addr[j] != 5'd0);
         for (int m = j + 1; m < LANES; m++) begin
            if (cv[m] && h_wen[m] && (h_addr[m] == h_addr[j])) begin
               ena[j] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      bus.commit_valid       = cv;
      bus.regfile_write_ena  = ena;
      bus.regfile_write_addr = '0;
      bus.regfile_write_data = '0;
      bus.commit_result      = '0;
      for (int j = 0; j < LANES; j++) begin
         if (cv[j]) begin
            bus.regfile_write_addr[j] = h_addr[j];
            bus.regfile_write_data[j] = h_data[j];
            bus.commit_result[j]      = h_data[j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + PW'(ret_k);
         if (enq_fire) begin
            tail_q <= tail_q + PW'(enq_n);
         end
         count_q <= count_q + (enq_fire ? enq_n : CW'(0)) - ret_k;
      end
   end

   always_ff @(posedge clk) begin
      if (enq_fire) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.in_valid[i]) begin
               mem_wen [tail_q + PW'(i)] <= bus.in_wen[i];
               mem_addr[tail_q + PW'(i)] <= bus.in_addr[i];
               mem_data[tail_q + PW'(i)] <= bus.in_data[i];
            end
         end
      end
   end
endmodule

// File: tb/tb_commit_queue.sv
// tb_commit_queue -- directed, table-driven bench for commit_queue
// (LANES=2, DEPTH=8), plus hand-written sequences for stall/full, flush,
// pointer wrap and asynchronous reset.
module tb_commit_queue;
   localparam int LANES = 2;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   commit_queue_if #(.LANES(LANES), .DEPTH(DEPTH)) bus ();

   commit_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [1:0]  v;
      logic [1:0]  w;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  e_ena;
      logic [1:0]  e_cv;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] w,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
      bus.in_valid   = v;
      bus.in_wen     = w;
      bus.in_addr[0] = a0;
      bus.in_addr[1] = a1;
      bus.in_data[0] = d0;
      bus.in_data[1] = d1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] e;
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      drive(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

      vecs[0] = '{2'b11, 2'b11, 5'd3, 5'd4, 32'h11, 32'h22, 2'b11, 2'b11, 4'd2};
      vecs[1] = '{2'b11, 2'b11, 5'd5, 5'd5, 32'hA, 32'hB, 2'b10, 2'b11, 4'd2};
      vecs[2] = '{2'b11, 2'b01, 5'd0, 5'd2, 32'h7, 32'h9, 2'b00, 2'b11, 4'd2};
      vecs[3] = '{2'b01, 2'b01, 5'd7, 5'd0, 32'h1234, 32'h0, 2'b01, 2'b01, 4'd1};
      vecs[4] = '{2'b11, 2'b11, 5'd1, 5'd31, 32'hDEAD, 32'hBEEF, 2'b11, 2'b11, 4'd2};
      vecs[5] = '{2'b11, 2'b10, 5'd6, 5'd6, 32'h66, 32'h67, 2'b10, 2'b11, 4'd2};

      // Reset state, asserted from time zero.
      #2;
      chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset_count", 64'(bus.count), 64'd0);
      chk("reset_cv", 64'(bus.commit_valid), 64'd0);
      chk("reset_ena", 64'(bus.regfile_write_ena), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Table-driven single-group vectors.
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].v, vecs[i].w, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
         #1;
         chk($sformatf("v%0d_ready", i), 64'(bus.in_ready), 64'd1);
         tick();
         drive(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
         #1;
         chk($sformatf("v%0d_count", i), 64'(bus.count), 64'(vecs[i].e_cnt));
         chk($sformatf("v%0d_cv", i), 64'(bus.commit_valid), 64'(vecs[i].e_cv));
         chk($sformatf("v%0d_ena", i), 64'(bus.regfile_write_ena), 64'(vecs[i].e_ena));
         chk($sformatf("v%0d_waddr0", i), 64'(bus.regfile_write_addr[0]),
             vecs[i].e_cv[0] ? 64'(vecs[i].a0) : 64'd0);
         chk($sformatf("v%0d_waddr1", i), 64'(bus.regfile_write_addr[1]),
             vecs[i].e_cv[1] ? 64'(vecs[i].a1) : 64'd0);
         chk($sformatf("v%0d_wdata0", i), 64'(bus.regfile_write_data[0]),
             vecs[i].e_cv[0] ? 64'(vecs[i].d0) : 64'd0);
         chk($sformatf("v%0d_wdata1", i), 64'(bus.regfile_write_data[1]),
             vecs[i].e_cv[1] ? 64'(vecs[i].d1) : 64'd0);
         if (vecs[i].e_cv[0]) chk($sformatf("v%0d_res0", i), 64'(bus.commit_result[0]), 64'(vecs[i].d0));
         if (vecs[i].e_cv[1]) chk($sformatf("v%0d_res1", i), 64'(bus.commit_result[1]), 64'(vecs[i].d1));
         tick();
         chk($sformatf("v%0d_drained", i), 64'(bus.count), 64'd0);
      end

      // Stall while filling to DEPTH; a fifth group is ignored.
      bus.stall = 1'b1;
      for (int g = 0; g < 4; g++) begin
         drive(2'b11, 2'b11, 5'(g + 1), 5'(g + 9), 32'h100 + 32'(2 * g), 32'h101 + 32'(2 * g));
         exp_q.push_back(32'h100 + 32'(2 * g));
         exp_q.push_back(32'h101 + 32'(2 * g));
         #1;
         chk($sformatf("stall_cv_g%0d", g), 64'(bus.commit_valid), 64'd0);
         tick();
      end
      chk("full_count", 64'(bus.count), 64'd8);
      chk("full_ready", 64'(bus.in_ready), 64'd0);
      drive(2'b11, 2'b11, 5'd20, 5'd21, 32'hBAD0, 32'hBAD1);
      tick();
      chk("full_ignored_count", 64'(bus.count), 64'd8);
      drive(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      bus.stall = 1'b0;
      #1;
      chk("full_ready_while_retiring", 64'(bus.in_ready), 64'd0);
      for (int r = 0; r < 4; r++) begin
         chk($sformatf("drain_cv_%0d", r), 64'(bus.commit_valid), 64'd3);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
         chk($sformatf("drain_res0_%0d", r), 64'(bus.commit_result[0]), 64'(e));
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
         chk($sformatf("drain_res1_%0d", r), 64'(bus.commit_result[1]), 64'(e));
         tick();
         chk($sformatf("drain_count_%0d", r), 64'(bus.count), 64'(8 - 2 * (r + 1)));
         chk($sformatf("drain_ready_%0d", r), 64'(bus.in_ready), 64'd1);
      end

      // Fill to 5, then flush with a group presented.
      bus.stall = 1'b1;
      drive(2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2);
      tick();
      drive(2'b11, 2'b11, 5'd3, 5'd4, 32'h3, 32'h4);
      tick();
      drive(2'b01, 2'b01, 5'd5, 5'd0, 32'h5, 32'h0);
      tick();
      chk("pre_flush_count", 64'(bus.count), 64'd5);
      bus.stall = 1'b0;
      bus.flush = 1'b1;
      drive(2'b11, 2'b11, 5'd8, 5'd9, 32'h88, 32'h99);
      #1;
      chk("flush_ena", 64'(bus.regfile_write_ena), 64'd0);
      chk("flush_cv", 64'(bus.commit_valid), 64'd0);
      tick();
      bus.flush = 1'b0;
      drive(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      #1;
      chk("post_flush_count", 64'(bus.count), 64'd0);
      chk("post_flush_cv", 64'(bus.commit_valid), 64'd0);

      // Move head and tail to index 7, then enqueue across the wrap.
      bus.stall = 1'b1;
      for (int g = 0; g < 3; g++) begin
         drive(2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2);
         tick();
      end
      drive(2'b01, 2'b01, 5'd1, 5'd0, 32'h1, 32'h0);
      tick();
      chk("wrap_fill_count", 64'(bus.count), 64'd7);
      drive(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      bus.stall = 1'b0;
      for (int r = 0; r < 4; r++) begin
         tick();
         chk($sformatf("wrap_drain_%0d", r), 64'(bus.count), (r < 3) ? 64'(5 - 2 * r) : 64'd0);
      end
      drive(2'b11, 2'b11, 5'd10, 5'd11, 32'hA7, 32'hA0);
      tick();
      drive(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      #1;
      chk("wrap_cv", 64'(bus.commit_valid), 64'd3);
      chk("wrap_res0", 64'(bus.commit_result[0]), 64'hA7);
      chk("wrap_res1", 64'(bus.commit_result[1]), 64'hA0);
      chk("wrap_ena", 64'(bus.regfile_write_ena), 64'd3);
      chk("wrap_waddr0", 64'(bus.regfile_write_addr[0]), 64'd10);
      chk("wrap_waddr1", 64'(bus.regfile_write_addr[1]), 64'd11);
      tick();
      chk("wrap_count", 64'(bus.count), 64'd0);

      // Asynchronous reset in the middle of a cycle with entries retiring.
      bus.stall = 1'b1;
      drive(2'b11, 2'b11, 5'd12, 5'd13, 32'hC0, 32'hC1);
      tick();
      drive(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      bus.stall = 1'b0;
      #1;
      chk("pre_rst_cv", 64'(bus.commit_valid), 64'd3);
      rst_n = 1'b0;
      #1;
      chk("rst_cv", 64'(bus.commit_valid), 64'd0);
      chk("rst_ena", 64'(bus.regfile_write_ena), 64'd0);
      chk("rst_waddr", 64'(bus.regfile_write_addr), 64'd0);
      chk("rst_wdata", 64'(bus.regfile_write_data), 64'd0);
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_ready", 64'(bus.in_ready), 64'd1);
      tick();
      rst_n = 1'b1;
      #1;
      chk("post_rst_cv", 64'(bus.commit_valid), 64'd0);
      tick();
      chk("post_rst_count", 64'(bus.count), 64'd0);

      // Queue still works after reset.
      drive(2'b11, 2'b11, 5'd14, 5'd15, 32'hE0, 32'hE1);
      tick();
      drive(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      #1;
      chk("after_rst_cv", 64'(bus.commit_valid), 64'd3);
      chk("after_rst_res0", 64'(bus.commit_result[0]), 64'hE0);
      chk("after_rst_res1", 64'(bus.commit_result[1]), 64'hE1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
